// File: rtl/div_sequencer_pkg.sv
// Shared types, widths and constants for the iterative divider.
//   div_state_type : sequencer states IDLE / RUN / DONE
//   div_op_type    : one-hot decoded division operation {divs, divu, rem, remu}
//   div_min_signed / div_all_ones : signed-overflow and divide-by-zero patterns
package div_sequencer_pkg;

  localparam int unsigned data_width = 32;
  localparam int unsigned cnt_width  = 5;

  localparam logic [data_width-1:0] div_min_signed = 32'h8000_0000;
  localparam logic [data_width-1:0] div_all_ones   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_type;

  typedef struct packed {
    logic divs;
    logic divu;
    logic rem;
    logic remu;
  } div_op_type;

  localparam div_op_type div_op_init = div_op_type'(4'b0000);

  // True when exactly one operation bit is set.
  function automatic logic op_is_one_hot(input div_op_type o);
    logic [3:0] v;
    v = o;
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [data_width-1:0] abs_val(input logic [data_width-1:0] x);
    return x[data_width-1] ? (data_width'(0) - x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration (combinational).
//   rem      : 33-bit partial remainder in
//   quo      : quotient / remaining dividend bits in
//   divisor  : unsigned divisor magnitude
//   rem_next : partial remainder after this step
//   quo_next : quotient after this step (new bit shifted in at LSB)
module div_step
  import div_sequencer_pkg::*;
(
  input  logic [data_width:0]   rem,
  input  logic [data_width-1:0] quo,
  input  logic [data_width-1:0] divisor,
  output logic [data_width:0]   rem_next,
  output logic [data_width-1:0] quo_next
);

  logic [data_width:0] shifted;
  logic                fits;

  always_comb begin
    shifted  = {rem[data_width-1:0], quo[data_width-1]};
    // A set top bit would shift out beyond 33 bits, so the divisor always fits.
    fits     = rem[data_width] | (shifted >= {1'b0, divisor});
    rem_next = shifted;
    quo_next = {quo[data_width-2:0], 1'b0};
    if (fits) begin
      rem_next = shifted - {1'b0, divisor};
      quo_next = {quo[data_width-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// 32-bit iterative divider sequencer: 32-cycle restoring division with
// signed fix-up, single-cycle divide-by-zero and signed-overflow results.
//   clock, reset  : rising-edge clock, synchronous active-low reset
//   start, op     : one-cycle request with one-hot operation
//   rdata1/rdata2 : dividend / divisor
//   flush         : abort, returns to IDLE next cycle
//   busy          : high whenever not IDLE
//   ready, result : one-cycle valid pulse with quotient or remainder
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  div_op_type            op,
  input  logic [data_width-1:0] rdata1,
  input  logic [data_width-1:0] rdata2,
  input  logic                  flush,
  output logic                  busy,
  output logic                  ready,
  output logic [data_width-1:0] result
);

  div_state_type         state;
  logic [cnt_width-1:0]  cnt;
  logic [data_width:0]   rem_q;
  logic [data_width-1:0] quo_q;
  logic [data_width-1:0] dvsr_q;
  div_op_type            op_q;
  logic                  sign_a;
  logic                  sign_b;

  logic [data_width:0]   rem_next;
  logic [data_width-1:0] quo_next;

  logic                  is_signed_c;
  logic                  div_zero_c;
  logic                  overflow_c;
  logic [data_width-1:0] special_c;
  logic [data_width-1:0] quot_fix_c;
  logic [data_width-1:0] rem_fix_c;
  logic [data_width-1:0] final_c;

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Request classification and single-cycle special results.
  always_comb begin
    is_signed_c = op.divs | op.rem;
    div_zero_c  = (rdata2 == data_width'(0));
    overflow_c  = is_signed_c && (rdata1 == div_min_signed) && (rdata2 == div_all_ones);
    special_c   = data_width'(0);
    if (div_zero_c) begin
      special_c = (op.divs | op.divu) ? div_all_ones : rdata1;
    end else if (overflow_c) begin
      special_c = op.divs ? div_min_signed : data_width'(0);
    end
  end

  // Sign fix-up applied to the last step's output.
  always_comb begin
    quot_fix_c = (op_q.divs && (sign_a ^ sign_b)) ? (data_width'(0) - quo_next) : quo_next;
    rem_fix_c  = (op_q.rem && sign_a) ? (data_width'(0) - rem_next[data_width-1:0])
                                      : rem_next[data_width-1:0];
    final_c    = data_width'(0);
    if (op_q.divs | op_q.divu) begin
      final_c = quot_fix_c;
    end else if (op_q.rem | op_q.remu) begin
      final_c = rem_fix_c;
    end
  end

  // Sequencer: state, operands and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      ready  <= 1'b0;
      result <= data_width'(0);
      cnt    <= cnt_width'(0);
      rem_q  <= (data_width + 1)'(0);
      quo_q  <= data_width'(0);
      dvsr_q <= data_width'(0);
      op_q   <= div_op_init;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && op_is_one_hot(op)) begin
              busy <= 1'b1;
              if (div_zero_c || overflow_c) begin
                state  <= DONE;
                ready  <= 1'b1;
                result <= special_c;
              end else begin
                state  <= RUN;
                cnt    <= cnt_width'(31);
                op_q   <= op;
                sign_a <= rdata1[data_width-1];
                sign_b <= rdata2[data_width-1];
                rem_q  <= (data_width + 1)'(0);
                quo_q  <= is_signed_c ? abs_val(rdata1) : rdata1;
                dvsr_q <= is_signed_c ? abs_val(rdata2) : rdata2;
              end
            end
          end
          RUN: begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (cnt == cnt_width'(0)) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= final_c;
            end else begin
              cnt <= cnt - cnt_width'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have the following ports, all synchronous to one clock, with reset synchronous and active-low:
- reset  in  1  synchronous active-low reset
- clock  in  1  rising-edge clock
- start  in  1  one-cycle request carrying a decoded division operation
- op  in  div_op_type  one-hot {divs, divu, rem, remu}, sampled with start
- rdata1  in  32  dividend (rs1 value)
- rdata2  in  32  divisor (rs2 value)
- flush  in  1  abort of the current operation (pipeline clear)
- busy  out  1  high in every state other than IDLE
- ready  out  1  one-cycle pulse; result is valid in that cycle
- result  out  32  quotient or remainder

REQ-002 SHALL have no parameters; operand width is fixed at 32.

Function
REQ-003 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-004 IDLE to RUN: on start=1 when op has exactly one bit set and the divisor is nonzero and the operation is not signed overflow.
- Operands, op and signs are latched on this transition.
- For signed ops, absolute values are latched.
REQ-005 IDLE to DONE: on start=1 when the divisor is 0 or when signed overflow applies (divs/rem, dividend 0x80000000, divisor 0xFFFFFFFF).
- The special result is latched on this transition.
REQ-006 start SHALL be ignored when op is zero or multi-hot, and whenever the FSM is not in IDLE.
REQ-007 RUN SHALL perform one restoring shift-subtract step per cycle.
- A 5-bit counter is loaded with 31 on entry and decrements each cycle.
- The FSM moves to DONE in the cycle the counter is 0, giving exactly 32 RUN cycles.
REQ-008 Sign fix-up SHALL be applied on the RUN-to-DONE transition.
- Quotient is negated when the operand signs differ (divs).
- Remainder takes the sign of the dividend (rem).
- divu/remu take no fix-up.
REQ-009 In DONE: ready=1 and result holds the selected value; the next state is IDLE unconditionally.
REQ-010 Latency from the start cycle T:
- Normal operation: ready in cycle T+33.
- Special cases: ready in cycle T+1.
- A new start is accepted from cycle T+34 (normal) or T+2 (special).
REQ-011 Divide-by-zero results:
- divs/divu: 0xFFFFFFFF.
- rem/remu: dividend unchanged.
REQ-012 Signed-overflow results:
- divs: 0x80000000.
- rem: 0x00000000.
REQ-013 flush=1 in any state SHALL force IDLE in the next cycle with ready=0 and no result update.
REQ-014 flush and start asserted together in IDLE: flush wins and the request is dropped.
REQ-015 flush in the DONE cycle SHALL not suppress that cycle's ready, which is already registered.
REQ-016 result SHALL hold its last value outside DONE; only the ready cycle is architecturally meaningful.
REQ-017 All arithmetic SHALL use a 33-bit partial remainder, with no truncation before the compare.

Reset
REQ-018 While reset=0 at a clock edge, SHALL enter IDLE with:
- busy=0, ready=0, result=0
- counter=0 and all latched operands at 0.
REQ-019 Reset asserted mid-RUN SHALL abandon the operation with no ready pulse.
- The first start after reset is released SHALL be accepted normally.

Structure
REQ-020 The state enum (IDLE, RUN, DONE) SHALL live in the shared wires package.
- Its typedef name is div_state_type.
REQ-021 div_op_type and its init value already exist in the shared package and SHALL be reused unchanged.
REQ-022 Constants 0x80000000 and 0xFFFFFFFF SHALL live in the shared constants package as div_min_signed and div_all_ones.
REQ-023 One sub-module, div_step, SHALL hold the combinational single-iteration shift-subtract.
- Inputs: partial remainder, quotient, divisor.
- Outputs: next partial remainder, next quotient.
REQ-024 The implementation SHALL fit in 120-400 lines.

Verification
REQ-025 divu, 100 / 7 -> ready at T+33, result 14; remu on the same operands -> result 2.
REQ-026 divs 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD (-3); rem on the same operands -> result 0xFFFFFFFF (-1).
REQ-027 Division by zero:
- divu 5 / 0 -> ready at T+1, result 0xFFFFFFFF.
- remu 5 / 0 -> result 5.
REQ-028 divs 0x80000000 / 0xFFFFFFFF -> ready at T+1, result 0x80000000; rem on the same operands -> result 0.
REQ-029 Abort and restart:
- start divu 100 / 7, then flush at T+10 -> no ready ever appears and busy=0 at T+11.
- A following start of divu 9 / 3 -> result 3 at its own T+33.
- start held high during RUN -> ignored.
REQ-030 reset=0 at T+20 of a run -> busy=0, ready=0, result=0 next cycle; a subsequent 100 / 7 divu -> 14.
